// File: rtl/serial_bit_feeder_if.sv
// Word-in / bit-out bus between a parallel producer, the serial_bit_feeder and a
// single-bit sequence detector.
interface serial_bit_feeder_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             j;
  logic             j_valid;
  logic             last;
  logic             busy;

  // Producer/consumer side: drives words, observes the serial stream.
  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  j,
    input  j_valid,
    input  last,
    input  busy
  );

  // Feeder side.
  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output j,
    output j_valid,
    output last,
    output busy
  );
endinterface

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial front end: takes WIDTH-bit words over valid/ready and emits
// one registered bit per clock on j, streaming back-to-back words with no gap.
module serial_bit_feeder #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  serial_bit_feeder_if.slave  bus
);

  localparam int unsigned       CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               j_q, j_d;
  logic               j_valid_q, j_valid_d;
  logic               last_q, last_d;
  logic               busy_q, busy_d;

  logic               din_ready_c;
  logic               accept_c;

  // Bit that goes out first from a freshly loaded word.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Word with the bit currently on j consumed, next bit moved to the head.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // Ready in idle and on the final bit of a word so the next word follows with no gap.
  always_comb begin
    din_ready_c = rst & ((state_q == IDLE) | (count_q == LAST_CNT));
    accept_c    = bus.din_valid & din_ready_c;
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    count_d   = count_q;
    j_d       = IDLE_BIT;
    j_valid_d = 1'b0;
    last_d    = 1'b0;

    if (accept_c) begin
      state_d   = SHIFT;
      shift_d   = bus.din;
      count_d   = '0;
      j_d       = head_bit(bus.din);
      j_valid_d = 1'b1;
    end else begin
      case (state_q)
        SHIFT: begin
          if (count_q == LAST_CNT) begin
            state_d = IDLE;
            count_d = '0;
          end else begin
            shift_d   = advance(shift_q);
            count_d   = count_q + CNT_W'(1);
            j_d       = head_bit(advance(shift_q));
            j_valid_d = 1'b1;
            last_d    = ((count_q + CNT_W'(1)) == LAST_CNT);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d == SHIFT);
  end

  // Synchronous active-low reset discards any in-flight word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      count_q   <= '0;
      j_q       <= IDLE_BIT;
      j_valid_q <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      count_q   <= count_d;
      j_q       <= j_d;
      j_valid_q <= j_valid_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.din_ready = din_ready_c;
  assign bus.j         = j_q;
  assign bus.j_valid   = j_valid_q;
  assign bus.last      = last_q;
  assign bus.busy      = busy_q;

endmodule
